// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path: state encoding,
// default load wait and the state-to-stage one-hot decode.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_IF   = 3'd1,
      ST_ID   = 3'd2,
      ST_EXE  = 3'd3,
      ST_MEM  = 3'd4,
      ST_WB   = 3'd5
   } state_e;

   // Extra MEM cycles a load waits for data_sram read data.
   localparam int unsigned LD_WAIT_DEF = 1;

   // Width of the MEM wait down-counter (LD_WAIT is limited to 0..7).
   localparam int unsigned WAIT_W = 3;

   // Map a state to its one-hot {WB,MEM,EXE,ID,IF} stage code; IDLE is all-zero.
   function automatic logic [4:0] stage_onehot(input state_e s);
      logic [4:0] oh;
      case (s)
         ST_IF:   oh = 5'b00001;
         ST_ID:   oh = 5'b00010;
         ST_EXE:  oh = 5'b00100;
         ST_MEM:  oh = 5'b01000;
         ST_WB:   oh = 5'b10000;
         default: oh = 5'b00000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/stage_ctrl.sv
// Multi-cycle instruction sequencer: walks each instruction through
// IF/ID/EXE/[MEM]/WB, generates the per-stage strobes, and counts retirements.
// A stall freezes all state and masks every strobe for that cycle.
module stage_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned LD_WAIT = LD_WAIT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        halt,
   input  logic        dec_load,
   input  logic        dec_store,
   input  logic        dec_gr_we,
   input  logic        br_taken,
   output logic [4:0]  stage,
   output logic        inst_sram_en,
   output logic        ir_we,
   output logic        data_sram_en,
   output logic        data_sram_we,
   output logic        rf_we,
   output logic        pc_we,
   output logic        pc_sel_br,
   output logic        retire,
   output logic [31:0] retire_cnt
);

   localparam logic [WAIT_W-1:0] LD_WAIT_C = WAIT_W'(LD_WAIT);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              br_q, br_d;
   logic              mem_first_q, mem_first_d;
   logic [31:0]       retire_cnt_q, retire_cnt_d;
   logic              act_s;

   // State register and sequencing flops; reset abandons any in-flight instruction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         wait_q       <= '0;
         br_q         <= 1'b0;
         mem_first_q  <= 1'b0;
         retire_cnt_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         br_q         <= br_d;
         mem_first_q  <= mem_first_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // Next-state logic: a stall holds everything, otherwise advance one stage.
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      br_d         = br_q;
      mem_first_d  = mem_first_q;
      retire_cnt_d = retire_cnt_q;
      if (stall) begin
         state_d = state_q;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (halt) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_IF;
               end
            end
            ST_IF:  state_d = ST_ID;
            ST_ID:  state_d = ST_EXE;
            ST_EXE: begin
               br_d = br_taken;
               if (dec_load || dec_store) begin
                  state_d     = ST_MEM;
                  mem_first_d = 1'b1;
                  wait_d      = dec_load ? LD_WAIT_C : {WAIT_W{1'b0}};
               end else begin
                  state_d = ST_WB;
               end
            end
            ST_MEM: begin
               mem_first_d = 1'b0;
               if (wait_q == {WAIT_W{1'b0}}) begin
                  state_d = ST_WB;
               end else begin
                  wait_d = wait_q - {{(WAIT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_WB: begin
               br_d         = 1'b0;
               retire_cnt_d = retire_cnt_q + 32'd1;
               if (halt) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_IF;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Moore output decode of the held state; strobes are masked while stalled.
   always_comb begin
      act_s        = ~stall;
      stage        = stage_onehot(state_q);
      inst_sram_en = act_s && (state_q == ST_IF);
      ir_we        = act_s && (state_q == ST_ID);
      data_sram_en = act_s && (state_q == ST_MEM);
      data_sram_we = act_s && (state_q == ST_MEM) && mem_first_q && dec_store;
      rf_we        = act_s && (state_q == ST_WB) && dec_gr_we;
      pc_we        = act_s && (state_q == ST_WB);
      retire       = act_s && (state_q == ST_WB);
      pc_sel_br    = (state_q == ST_WB) && br_q;
   end

   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_stage_ctrl.sv
// Self-checking bench for stage_ctrl: a queue-of-stages reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_stage_ctrl;

   localparam int LDW = 2;

   logic        clk = 1'b0;
   logic        reset, stall, halt, dec_load, dec_store, dec_gr_we, br_taken;
   logic [4:0]  stage;
   logic        inst_sram_en, ir_we, data_sram_en, data_sram_we;
   logic        rf_we, pc_we, pc_sel_br, retire;
   logic [31:0] retire_cnt;

   always #5 clk = ~clk;

   stage_ctrl #(.LD_WAIT(LDW)) dut (
      .clk(clk), .reset(reset), .stall(stall), .halt(halt),
      .dec_load(dec_load), .dec_store(dec_store), .dec_gr_we(dec_gr_we),
      .br_taken(br_taken), .stage(stage), .inst_sram_en(inst_sram_en),
      .ir_we(ir_we), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
      .rf_we(rf_we), .pc_we(pc_we), .pc_sel_br(pc_sel_br), .retire(retire),
      .retire_cnt(retire_cnt)
   );

   int checks = 0;
   int errors = 0;

   // reference model: remaining stage codes of the current instruction
   int          q[$];
   bit          m_ld, m_st, m_gw, m_br;
   logic [31:0] m_cnt;
   int          next_type = -1;   // 0 add, 1 no-write alu/branch, 2 load, 3 store

   // last observed DUT values
   logic [4:0]  o_stage;
   bit          o_retire, o_dwe, o_rfwe, o_sel;
   logic [4:0]  first_stage;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic new_instr();
      int t;
      t    = (next_type < 0) ? int'($urandom_range(0, 3)) : next_type;
      m_ld = (t == 2);
      m_st = (t == 3);
      m_gw = (t == 0) || (t == 2);
      q.delete();
      q.push_back(1); q.push_back(2); q.push_back(4);
      if (m_ld) begin
         for (int i = 0; i < 1 + LDW; i++) q.push_back(8);
      end else if (m_st) begin
         q.push_back(8);
      end
      q.push_back(16);
   endtask

   // One clock cycle: drive inputs, compare against the model, advance the model.
   task automatic cyc(input bit st, input bit hl, input bit br);
      logic [4:0]  es;
      logic [12:0] exp_v, act_v;
      bit          a;
      int          s;
      stall = st; halt = hl; br_taken = br;
      dec_load = m_ld; dec_store = m_st; dec_gr_we = m_gw;
      #1;
      es = (q.size() > 0) ? 5'(q[0]) : 5'd0;
      a  = !st;
      exp_v = {es, a && es == 5'd1, a && es == 5'd2, a && es == 5'd8,
               a && es == 5'd8 && m_st, a && es == 5'd16 && m_gw, a && es == 5'd16,
               es == 5'd16 && m_br, a && es == 5'd16};
      act_v = {stage, inst_sram_en, ir_we, data_sram_en, data_sram_we,
               rf_we, pc_we, pc_sel_br, retire};
      chk("outputs", 32'(act_v), 32'(exp_v));
      chk("retire_cnt", retire_cnt, m_cnt);
      o_stage = stage; o_retire = retire; o_dwe = data_sram_we;
      o_rfwe = rf_we; o_sel = pc_sel_br;
      if (!st) begin
         if (q.size() == 0) begin
            if (!hl) new_instr();
         end else begin
            s = q.pop_front();
            if (s == 4) m_br = br;
            if (s == 16) begin
               m_cnt = m_cnt + 32'd1;
               m_br  = 1'b0;
               if (!hl) new_instr();
            end
         end
      end
      @(negedge clk);
   endtask

   // Launch one instruction from IDLE (halt held high afterwards) and observe it.
   task automatic run_instr(input int t, input bit br, input int st_start, input int st_len,
                            output int lat, output int mem_n, output int we_n,
                            output bit rf_wb, output bit sel_wb);
      bit done;
      bit st;
      done = 1'b0; lat = 0; mem_n = 0; we_n = 0; rf_wb = 1'b0; sel_wb = 1'b0;
      next_type = t;
      cyc(1'b0, 1'b0, 1'b0);
      while (!done && lat < 40) begin
         st = (lat >= st_start) && (lat < st_start + st_len);
         cyc(st, 1'b1, br);
         if (lat == 0) first_stage = o_stage;
         lat++;
         if (o_stage == 5'd8) mem_n++;
         if (o_dwe) we_n++;
         if (o_retire) begin
            done = 1'b1; rf_wb = o_rfwe; sel_wb = o_sel;
         end
      end
      if (!done) chk("retire_timeout", 32'd0, 32'd1);
      next_type = -1;
   endtask

   task automatic model_clear();
      q.delete(); m_cnt = 32'd0; m_br = 1'b0;
   endtask

   int lat, mem_n, we_n, guard;
   bit rf_wb, sel_wb;

   initial begin
      m_ld = 1'b0; m_st = 1'b0; m_gw = 1'b0;
      model_clear();
      stall = 1'b0; halt = 1'b1; dec_load = 1'b0; dec_store = 1'b0;
      dec_gr_we = 1'b0; br_taken = 1'b0; reset = 1'b1;
      #2;
      chk("reset_stage", 32'(stage), 32'd0);
      chk("reset_strobes", 32'({inst_sram_en, ir_we, data_sram_en, data_sram_we,
                               rf_we, pc_we, pc_sel_br, retire}), 32'd0);
      chk("reset_cnt", retire_cnt, 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;

      // add-type instruction
      run_instr(0, 1'b0, 99, 0, lat, mem_n, we_n, rf_wb, sel_wb);
      chk("add_first_if", 32'(first_stage), 32'd1);
      chk("add_latency", 32'(lat), 32'd4);
      chk("add_rf_we", 32'(rf_wb), 32'd1);
      chk("add_sel_br", 32'(sel_wb), 32'd0);
      chk("add_cnt", retire_cnt, 32'd1);

      // halted after retire: parked in IDLE, then resumes straight into IF
      cyc(1'b0, 1'b1, 1'b0);
      chk("halt_parked", 32'(o_stage), 32'd0);

      // load, LD_WAIT=2
      run_instr(2, 1'b0, 99, 0, lat, mem_n, we_n, rf_wb, sel_wb);
      chk("resume_if", 32'(first_stage), 32'd1);
      chk("load_latency", 32'(lat), 32'd7);
      chk("load_mem_cycles", 32'(mem_n), 32'd3);
      chk("load_we", 32'(we_n), 32'd0);
      chk("load_cnt", retire_cnt, 32'd2);

      // load with a 3-cycle stall in the middle of MEM
      run_instr(2, 1'b0, 4, 3, lat, mem_n, we_n, rf_wb, sel_wb);
      chk("stall_latency", 32'(lat), 32'd10);
      chk("stall_mem_cycles", 32'(mem_n), 32'd6);
      chk("stall_we", 32'(we_n), 32'd0);

      // reset asserted while a load sits in MEM
      next_type = 2;
      cyc(1'b0, 1'b0, 1'b0);
      guard = 0;
      while (o_stage != 5'd8 && guard < 10) begin
         cyc(1'b0, 1'b1, 1'b0);
         guard++;
      end
      chk("reach_mem", 32'(o_stage), 32'd8);
      next_type = -1;
      #2 reset = 1'b1;
      #1;
      chk("midreset_outputs", 32'({stage, inst_sram_en, ir_we, data_sram_en, data_sram_we,
                                  rf_we, pc_we, pc_sel_br, retire}), 32'd0);
      chk("midreset_cnt", retire_cnt, 32'd0);
      model_clear();
      halt = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // store then taken branch
      run_instr(3, 1'b0, 99, 0, lat, mem_n, we_n, rf_wb, sel_wb);
      chk("store_latency", 32'(lat), 32'd5);
      chk("store_we_cycles", 32'(we_n), 32'd1);
      chk("store_rf_we", 32'(rf_wb), 32'd0);
      run_instr(1, 1'b1, 99, 0, lat, mem_n, we_n, rf_wb, sel_wb);
      chk("branch_sel_br", 32'(sel_wb), 32'd1);
      chk("branch_cnt", retire_cnt, 32'd2);

      // retire counter wrap
      force dut.retire_cnt_q = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      cyc(1'b0, 1'b1, 1'b0);
      release dut.retire_cnt_q;
      run_instr(0, 1'b0, 99, 0, lat, mem_n, we_n, rf_wb, sel_wb);
      chk("wrap_cnt", retire_cnt, 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
